// File: rtl/control_step_sequencer.sv
`default_nettype none
// control_step_sequencer: Moore microsequencer driving fetch (T0-T2) and register-register
// ALU execute (T3-T5, T6 for MUL/DIV) strobes, with memory wait states and index checking.
module control_step_sequencer #(
   parameter int                  NUM_REGS    = 16,
   parameter int                  OPCODE_W    = 5,
   parameter logic [OPCODE_W-1:0] MUL_OPCODE  = 5'b01111,
   parameter logic [OPCODE_W-1:0] DIV_OPCODE  = 5'b10000,
   parameter int                  MEM_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                clear_n,
   input  logic                start,
   input  logic                run,
   input  logic [31:0]         ir,
   input  logic                mem_ready,
   output logic                PCout,
   output logic                ZLowout,
   output logic                ZHighout,
   output logic                MDRout,
   output logic                MAR_enable,
   output logic                PC_enable,
   output logic                mdr_read,
   output logic                MDRin,
   output logic                IR_enable,
   output logic                Yin,
   output logic                ZLow_enable,
   output logic                ZHigh_enable,
   output logic                HIin,
   output logic                LOin,
   output logic [NUM_REGS-1:0] reg_out,
   output logic [NUM_REGS-1:0] reg_in,
   output logic [OPCODE_W-1:0] alu_op,
   output logic [2:0]          step,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_T0   = 3'd1;
   localparam logic [2:0] S_T1   = 3'd2;
   localparam logic [2:0] S_T2   = 3'd3;
   localparam logic [2:0] S_T3   = 3'd4;
   localparam logic [2:0] S_T4   = 3'd5;
   localparam logic [2:0] S_T5   = 3'd6;
   localparam logic [2:0] S_T6   = 3'd7;
   localparam int         WAIT_W = $clog2(MEM_TIMEOUT + 1);

   logic [2:0]          state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                err_q, err_d;
   logic [3:0]          ra_q, rb_q, rc_q;
   logic [OPCODE_W-1:0] op_q;
   logic                muldiv;
   logic                final_step;
   logic                unused_ir;

   assign unused_ir  = ^ir[14:0];
   assign muldiv     = (op_q == MUL_OPCODE) || (op_q == DIV_OPCODE);
   assign final_step = (state_q == S_T6) || ((state_q == S_T5) && !muldiv);

   always_comb begin
      state_d = state_q;
      wait_d  = '0;
      err_d   = err_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_T0;
         S_T0:   state_d = S_T1;
         S_T1: begin
            if (mem_ready) begin
               state_d = S_T2;
            end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               wait_d  = wait_q + 1'b1;
            end
         end
         S_T2:   state_d = S_T3;
         S_T3: begin
            state_d = S_T4;
            if (32'(rb_q) >= NUM_REGS) err_d = 1'b1;
         end
         S_T4: begin
            state_d = S_T5;
            if (32'(rc_q) >= NUM_REGS) err_d = 1'b1;
         end
         S_T5: begin
            if (muldiv) begin
               state_d = S_T6;
            end else begin
               state_d = run ? S_T0 : S_IDLE;
               if (32'(ra_q) >= NUM_REGS) err_d = 1'b1;
            end
         end
         S_T6:    state_d = run ? S_T0 : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
         err_q   <= 1'b0;
         ra_q    <= '0;
         rb_q    <= '0;
         rc_q    <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         // Execute runs from a private copy so IR changes after T2 are harmless.
         if (state_q == S_T2) begin
            ra_q <= ir[26:23];
            rb_q <= ir[22:19];
            rc_q <= ir[18:15];
            op_q <= ir[31:32-OPCODE_W];
         end
      end
   end

   assign PCout        = (state_q == S_T0);
   assign MAR_enable   = (state_q == S_T0);
   assign ZLow_enable  = (state_q == S_T0) || (state_q == S_T4);
   assign ZLowout      = (state_q == S_T1) || (state_q == S_T5);
   assign PC_enable    = (state_q == S_T1) && (wait_q == '0);
   assign mdr_read     = (state_q == S_T1);
   assign MDRin        = (state_q == S_T1);
   assign MDRout       = (state_q == S_T2);
   assign IR_enable    = (state_q == S_T2);
   assign Yin          = (state_q == S_T3);
   assign ZHigh_enable = (state_q == S_T4) && muldiv;
   assign LOin         = (state_q == S_T5) && muldiv;
   assign HIin         = (state_q == S_T6);
   assign ZHighout     = (state_q == S_T6);
   assign alu_op       = (state_q == S_T4) ? op_q : '0;
   assign step         = (state_q == S_IDLE) ? 3'd0 : state_q - 3'd1;
   assign busy         = (state_q != S_IDLE);
   assign done         = final_step;
   assign err          = err_q;

   // Out-of-range indices simply match no bit, leaving the bus undriven.
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      assign reg_out[i] = ((state_q == S_T3) && (rb_q == 4'(i))) ||
                          ((state_q == S_T4) && (rc_q == 4'(i)));
      assign reg_in[i]  = (state_q == S_T5) && !muldiv && (ra_q == 4'(i));
   end

endmodule
`default_nettype wire

// File: tb/tb_control_step_sequencer.sv
`default_nettype none
// tb_control_step_sequencer: directed scoreboard bench; expected per-cycle strobe vectors
// are queued with the stimulus and popped one per clock.
module tb_control_step_sequencer;

   localparam int         NR    = 8;
   localparam logic [4:0] MULOP = 5'b01111;
   localparam logic [4:0] DIVOP = 5'b10000;

   logic        clk = 1'b0;
   logic        clear_n = 1'b0;
   logic        start = 1'b0;
   logic        run = 1'b0;
   logic        mem_ready = 1'b1;
   logic [31:0] ir = '0;

   logic PCout, ZLowout, ZHighout, MDRout, MAR_enable, PC_enable, mdr_read, MDRin;
   logic IR_enable, Yin, ZLow_enable, ZHigh_enable, HIin, LOin, busy, done, err;
   logic [NR-1:0] reg_out, reg_in;
   logic [4:0]    alu_op;
   logic [2:0]    step;
   logic [39:0]   act;

   control_step_sequencer #(
      .NUM_REGS(NR), .OPCODE_W(5), .MUL_OPCODE(MULOP), .DIV_OPCODE(DIVOP), .MEM_TIMEOUT(15)
   ) dut (
      .clk(clk), .clear_n(clear_n), .start(start), .run(run), .ir(ir), .mem_ready(mem_ready),
      .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
      .MAR_enable(MAR_enable), .PC_enable(PC_enable), .mdr_read(mdr_read), .MDRin(MDRin),
      .IR_enable(IR_enable), .Yin(Yin), .ZLow_enable(ZLow_enable), .ZHigh_enable(ZHigh_enable),
      .HIin(HIin), .LOin(LOin), .reg_out(reg_out), .reg_in(reg_in), .alu_op(alu_op),
      .step(step), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   assign act = {PCout, ZLowout, ZHighout, MDRout, MAR_enable, PC_enable, mdr_read, MDRin,
                 IR_enable, Yin, ZLow_enable, ZHigh_enable, HIin, LOin, done, busy,
                 step, alu_op, reg_out, reg_in};

   typedef struct {
      logic [39:0] exp;
      logic        mr;
      logic        st;
      logic        rn;
      logic [31:0] irv;
   } ent_t;

   ent_t q[$];
   int   compared = 0;
   int   mismatched = 0;

   // Expected outputs for step t (-1 = IDLE); first marks the first T1 cycle.
   function automatic logic [39:0] model(input int t, input logic [31:0] v, input bit first);
      logic [4:0] op;
      int ra, rb, rc;
      bit md;
      logic pco, zlo, zho, mdo, mar, pce, rd, mdi, ire, yin, zle, zhe, hi, lo, dn, by;
      logic [4:0] alu;
      logic [7:0] ro, ri;
      logic [2:0] st;
      op = v[31:27];
      ra = int'(v[26:23]);
      rb = int'(v[22:19]);
      rc = int'(v[18:15]);
      md = (op == MULOP) || (op == DIVOP);
      {pco, zlo, zho, mdo, mar, pce, rd, mdi, ire, yin, zle, zhe, hi, lo, dn, by} = '0;
      alu = '0; ro = '0; ri = '0; st = '0;
      if (t >= 0) begin
         by = 1'b1;
         st = 3'(t);
      end
      case (t)
         0: begin pco = 1'b1; mar = 1'b1; zle = 1'b1; end
         1: begin zlo = 1'b1; pce = first; rd = 1'b1; mdi = 1'b1; end
         2: begin mdo = 1'b1; ire = 1'b1; end
         3: begin yin = 1'b1; if (rb < NR) ro[rb] = 1'b1; end
         4: begin alu = op; zle = 1'b1; zhe = md; if (rc < NR) ro[rc] = 1'b1; end
         5: begin
            zlo = 1'b1;
            if (md) lo = 1'b1;
            else begin
               dn = 1'b1;
               if (ra < NR) ri[ra] = 1'b1;
            end
         end
         6: begin zho = 1'b1; hi = 1'b1; dn = 1'b1; end
         default: ;
      endcase
      return {pco, zlo, zho, mdo, mar, pce, rd, mdi, ire, yin, zle, zhe, hi, lo, dn, by,
              st, alu, ro, ri};
   endfunction

   task automatic chk(input string tag, input logic [39:0] o, input logic [39:0] x);
      compared++;
      assert (o === x) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, o, x);
      end
   endtask

   // Each entry carries the inputs to apply for the edge that ends its cycle.
   task automatic push_instr(input logic [31:0] v, input int waits, input bit tmo,
                             input bit rn, input logic [31:0] v_after, input bit start_mid);
      ent_t e;
      bit   md;
      int   n1;
      md    = (v[31:27] == MULOP) || (v[31:27] == DIVOP);
      n1    = tmo ? 15 : waits + 1;
      e.st  = 1'b0; e.rn = rn; e.irv = v; e.mr = 1'b1;
      e.exp = model(0, v, 1'b0); q.push_back(e);
      for (int k = 0; k < n1; k++) begin
         e.exp = model(1, v, k == 0);
         e.mr  = !tmo && (k == waits);
         q.push_back(e);
      end
      e.mr = 1'b1;
      if (tmo) begin
         e.exp = model(-1, v, 1'b0); q.push_back(e);
         return;
      end
      e.exp = model(2, v, 1'b0); q.push_back(e);
      e.irv = v_after;
      e.st  = start_mid;
      e.exp = model(3, v, 1'b0); q.push_back(e);
      e.st  = 1'b0;
      e.exp = model(4, v, 1'b0); q.push_back(e);
      e.exp = model(5, v, 1'b0); q.push_back(e);
      if (md) begin
         e.exp = model(6, v, 1'b0); q.push_back(e);
      end
      if (!rn) begin
         e.exp = model(-1, v, 1'b0); q.push_back(e);
      end
   endtask

   task automatic kick(input logic [31:0] v, input bit rn);
      ent_t e;
      ir = v; run = rn; mem_ready = 1'b1; start = 1'b1;
      while (q.size() > 0) begin
         @(posedge clk); #1;
         e = q.pop_front();
         chk("seq", act, e.exp);
         mem_ready = e.mr; start = e.st; run = e.rn; ir = e.irv;
      end
   endtask

   logic [31:0] ir1, ir2, irA, irB, ir6;

   initial begin
      ir1 = 32'h2A2B8000;
      ir2 = {MULOP, 4'd1, 4'd2, 4'd3, 15'd0};
      irA = {5'b00011, 4'd6, 4'd0, 4'd1, 15'd0};
      irB = {DIVOP, 4'd0, 4'd4, 4'd5, 15'd0};
      ir6 = {5'b00101, 4'd9, 4'd1, 4'd2, 15'd0};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", act, '0);
      chk("reset_err", {39'd0, err}, '0);
      clear_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_outputs", act, '0);

      push_instr(ir1, 0, 1'b0, 1'b0, ir1, 1'b0);
      kick(ir1, 1'b0);

      push_instr(ir2, 0, 1'b0, 1'b0, ir2, 1'b0);
      kick(ir2, 1'b0);

      push_instr(ir1, 3, 1'b0, 1'b0, ir1, 1'b0);
      kick(ir1, 1'b0);

      push_instr(irA, 0, 1'b0, 1'b1, irB, 1'b1);
      push_instr(irB, 1, 1'b0, 1'b0, irA, 1'b0);
      kick(irA, 1'b1);
      chk("err_clean", {39'd0, err}, '0);

      push_instr(ir1, 0, 1'b1, 1'b0, ir1, 1'b0);
      kick(ir1, 1'b0);
      chk("timeout_err", {39'd0, err}, 40'd1);

      clear_n = 1'b0;
      #1;
      clear_n = 1'b1;
      chk("err_cleared", {39'd0, err}, '0);

      push_instr(ir6, 0, 1'b0, 1'b0, ir6, 1'b0);
      kick(ir6, 1'b0);
      chk("badidx_err", {39'd0, err}, 40'd1);

      ir = ir1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("reach_t4", {37'd0, step}, 40'd4);
      clear_n = 1'b0;
      #1;
      chk("async_clear_outputs", act, '0);
      chk("async_clear_err", {39'd0, err}, '0);
      clear_n = 1'b1;
      @(posedge clk); #1;
      chk("after_clear_idle", act, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
